// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared pipeline types for the writeback stage.
//   wb_src_e       writeback source select
//   data_mem_op_e  data memory operation (load variants drive alignment)
//   uop_st         decoded micro-op fields carried to writeback
//   inst_packet_st packet handed from the memory stage
package writeback_stage_pkg;

    typedef enum logic [1:0] {
        WB_SRC_ALU,
        WB_SRC_MEM,
        WB_SRC_CSR,
        WB_SRC_PC4
    } wb_src_e;

    typedef enum logic [2:0] {
        DATA_MEM_NONE,
        LOAD_BYTE,
        LOAD_BYTE_U,
        LOAD_HALF,
        LOAD_HALF_U,
        LOAD_WORD,
        DATA_MEM_STORE
    } data_mem_op_e;

    typedef struct packed {
        wb_src_e      wb_src;
        logic         rd_w_en;
        data_mem_op_e data_mem_op;
    } uop_st;

    typedef struct packed {
        logic [31:0] pc;
        uop_st       uop;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] data_mem_r_data;
        logic [31:0] csr_r_data;
    } inst_packet_st;

endpackage

// File: rtl/inst_packet_if.sv
// inst_packet_if: valid/ready handshake carrying an inst_packet_st.
//   in  modport: sink side (reads valid/inst_packet, drives ready)
//   out modport: source side
interface inst_packet_if;
    import writeback_stage_pkg::*;
    logic          valid;
    logic          ready;
    inst_packet_st inst_packet;
    modport in  (input valid, input inst_packet, output ready);
    modport out (output valid, output inst_packet, input ready);
endinterface

// File: rtl/writeback_stage_load_align.sv
// writeback_stage_load_align: aligns and extends load data.
//   r_data_i  raw 32-bit word read from data memory
//   offset_i  byte offset within the word (address bits [1:0])
//   op_i      load variant
//   value_o   aligned, sign/zero-extended result
module writeback_stage_load_align
    import writeback_stage_pkg::*;
(
    input  logic [31:0]  r_data_i,
    input  logic [1:0]   offset_i,
    input  data_mem_op_e op_i,
    output logic [31:0]  value_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    assign byte_v = r_data_i[{offset_i, 3'b000} +: 8];
    // Odd half offsets are trapped upstream, so only bit 1 selects the half.
    assign half_v = r_data_i[{offset_i[1], 4'b0000} +: 16];
    always_comb begin
        value_o = op_i == LOAD_BYTE   ? {{24{byte_v[7]}}, byte_v} :
                  op_i == LOAD_BYTE_U ? {24'd0, byte_v} :
                  op_i == LOAD_HALF   ? {{16{half_v[15]}}, half_v} :
                  op_i == LOAD_HALF_U ? {16'd0, half_v} :
                  r_data_i;
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage; selects writeback data, drives the
// regfile write port, keeps a last-write bypass record and a retire counter.
//   i_clk/i_rst_n     clock, synchronous active-low reset
//   i_flush, i_stall  drop in-flight packet / deassert ready
//   if_memory_in      packet from the memory stage
//   o_rf_w_*          regfile write port (combinational)
//   o_byp_*           registered last-write record
//   o_retire(_cnt)    retire pulse and retired-instruction count
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int RETIRE_CNT_W = 64,
    parameter bit BYPASS_EN    = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_flush,
    input  logic                    i_stall,
    inst_packet_if.in               if_memory_in,
    output logic                    o_rf_w_en,
    output logic [4:0]              o_rf_w_addr,
    output logic [31:0]             o_rf_w_data,
    output logic                    o_byp_valid,
    output logic [4:0]              o_byp_addr,
    output logic [31:0]             o_byp_data,
    output logic                    o_retire,
    output logic [RETIRE_CNT_W-1:0] o_retire_cnt
);
    inst_packet_st           pkt;
    logic                    hs;
    logic [31:0]             load_val;
    logic [31:0]             wb_val;
    logic [RETIRE_CNT_W-1:0] cnt_q, cnt_d;

    assign pkt                = if_memory_in.inst_packet;
    assign if_memory_in.ready = !i_stall;
    assign hs                 = if_memory_in.valid && !i_stall;

    writeback_stage_load_align u_load_align (
        .r_data_i (pkt.data_mem_r_data),
        .offset_i (pkt.alu_result[1:0]),
        .op_i     (pkt.uop.data_mem_op),
        .value_o  (load_val)
    );

    always_comb begin
        wb_val = pkt.uop.wb_src == WB_SRC_ALU ? pkt.alu_result :
                 pkt.uop.wb_src == WB_SRC_MEM ? load_val :
                 pkt.uop.wb_src == WB_SRC_CSR ? pkt.csr_r_data :
                 pkt.pc + 32'd4;
    end

    // x0 writes are dropped here so downstream never sees them.
    assign o_rf_w_en   = i_rst_n && hs && pkt.uop.rd_w_en && pkt.rd != 5'd0 && !i_flush;
    assign o_rf_w_addr = pkt.rd;
    assign o_rf_w_data = wb_val;
    assign o_retire    = hs && !i_flush;

    always_comb cnt_d = o_retire ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign o_retire_cnt = cnt_q;

    if (BYPASS_EN) begin : g_byp
        logic        byp_valid_q, byp_valid_d;
        logic [4:0]  byp_addr_q, byp_addr_d;
        logic [31:0] byp_data_q, byp_data_d;
        // A consumed packet that does not write invalidates the record.
        always_comb begin
            byp_valid_d = i_flush ? 1'b0 : o_rf_w_en ? 1'b1 : hs ? 1'b0 : byp_valid_q;
            byp_addr_d  = o_rf_w_en ? pkt.rd : byp_addr_q;
            byp_data_d  = o_rf_w_en ? wb_val : byp_data_q;
        end
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                byp_valid_q <= 1'b0;
                byp_addr_q  <= '0;
                byp_data_q  <= '0;
            end else begin
                byp_valid_q <= byp_valid_d;
                byp_addr_q  <= byp_addr_d;
                byp_data_q  <= byp_data_d;
            end
        end
        assign o_byp_valid = byp_valid_q;
        assign o_byp_addr  = byp_addr_q;
        assign o_byp_data  = byp_data_q;
    end else begin : g_no_byp
        assign o_byp_valid = 1'b0;
        assign o_byp_addr  = '0;
        assign o_byp_data  = '0;
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: table, directed and random checks of writeback_stage.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, stall;
    logic        w_en, byp_v, ret, w_en4, byp_v4, ret4;
    logic [4:0]  w_addr, byp_a, w_addr4, byp_a4;
    logic [31:0] w_data, byp_d, w_data4, byp_d4;
    logic [63:0] cnt;
    logic [3:0]  cnt4;

    int checks = 0;
    int errors = 0;

    logic        m_bv;
    logic [4:0]  m_ba;
    logic [31:0] m_bd;
    logic [63:0] m_cnt;

    always #5 clk = ~clk;

    inst_packet_if if_m ();
    inst_packet_if if_4 ();
    assign if_4.valid       = if_m.valid;
    assign if_4.inst_packet = if_m.inst_packet;

    writeback_stage dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_stall(stall),
        .if_memory_in(if_m),
        .o_rf_w_en(w_en), .o_rf_w_addr(w_addr), .o_rf_w_data(w_data),
        .o_byp_valid(byp_v), .o_byp_addr(byp_a), .o_byp_data(byp_d),
        .o_retire(ret), .o_retire_cnt(cnt)
    );

    writeback_stage #(.RETIRE_CNT_W(4), .BYPASS_EN(1'b0)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_stall(stall),
        .if_memory_in(if_4),
        .o_rf_w_en(w_en4), .o_rf_w_addr(w_addr4), .o_rf_w_data(w_data4),
        .o_byp_valid(byp_v4), .o_byp_addr(byp_a4), .o_byp_data(byp_d4),
        .o_retire(ret4), .o_retire_cnt(cnt4)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic inst_packet_st mk(input wb_src_e s, input data_mem_op_e op, input logic [4:0] rd,
                                         input logic we, input logic [31:0] pc, input logic [31:0] alu,
                                         input logic [31:0] rdat, input logic [31:0] csr);
        inst_packet_st p;
        p.pc = pc;
        p.uop.wb_src = s;
        p.uop.rd_w_en = we;
        p.uop.data_mem_op = op;
        p.rd = rd;
        p.alu_result = alu;
        p.data_mem_r_data = rdat;
        p.csr_r_data = csr;
        return p;
    endfunction

    // Load value from shifting and masking, then two's-complement extension.
    function automatic logic [31:0] ref_load(input data_mem_op_e op, input logic [31:0] addr, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * addr[1:0])) & 32'hFF;
        h = (d >> (16 * addr[1])) & 32'hFFFF;
        case (op)
            LOAD_BYTE:   return b >= 32'd128 ? b - 32'd256 : b;
            LOAD_BYTE_U: return b;
            LOAD_HALF:   return h >= 32'd32768 ? h - 32'd65536 : h;
            LOAD_HALF_U: return h;
            default:     return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_wb(input inst_packet_st p);
        case (p.uop.wb_src)
            WB_SRC_ALU: return p.alu_result;
            WB_SRC_MEM: return ref_load(p.uop.data_mem_op, p.alu_result, p.data_mem_r_data);
            WB_SRC_CSR: return p.csr_r_data;
            default:    return p.pc + 32'd4;
        endcase
    endfunction

    task automatic cycle(input logic v, input logic st, input logic fl, input logic rn, input inst_packet_st p,
                         output logic g_ready, output logic g_wen, output logic [31:0] g_data, output logic g_ret);
        logic        e_hs, e_wen, e_ret;
        logic [31:0] e_val;
        @(negedge clk);
        if_m.valid = v;
        if_m.inst_packet = p;
        stall = st;
        flush = fl;
        rst_n = rn;
        #1;
        e_hs  = v && !st;
        e_wen = rn && e_hs && p.uop.rd_w_en && p.rd != 5'd0 && !fl;
        e_ret = e_hs && !fl;
        e_val = ref_wb(p);
        g_ready = if_m.ready;
        g_wen = w_en;
        g_data = w_data;
        g_ret = ret;
        chk("ready", {63'd0, if_m.ready}, {63'd0, !st});
        chk("ready4", {63'd0, if_4.ready}, {63'd0, !st});
        chk("w_en", {63'd0, w_en}, {63'd0, e_wen});
        chk("w_en4", {63'd0, w_en4}, {63'd0, e_wen});
        chk("w_addr", {59'd0, w_addr}, {59'd0, p.rd});
        chk("w_addr4", {59'd0, w_addr4}, {59'd0, p.rd});
        chk("w_data", {32'd0, w_data}, {32'd0, e_val});
        chk("w_data4", {32'd0, w_data4}, {32'd0, e_val});
        chk("retire", {63'd0, ret}, {63'd0, e_ret});
        chk("retire4", {63'd0, ret4}, {63'd0, e_ret});
        if (!rn) begin
            m_bv = 1'b0; m_ba = '0; m_bd = '0; m_cnt = '0;
        end else begin
            if (fl) m_bv = 1'b0;
            else if (e_wen) begin m_bv = 1'b1; m_ba = p.rd; m_bd = e_val; end
            else if (e_hs) m_bv = 1'b0;
            if (e_ret) m_cnt = m_cnt + 64'd1;
        end
        @(posedge clk);
        #1;
        chk("byp_valid", {63'd0, byp_v}, {63'd0, m_bv});
        chk("byp_addr", {59'd0, byp_a}, {59'd0, m_ba});
        chk("byp_data", {32'd0, byp_d}, {32'd0, m_bd});
        chk("retire_cnt", cnt, m_cnt);
        chk("retire_cnt4", {60'd0, cnt4}, {60'd0, m_cnt[3:0]});
        chk("byp_off", {26'd0, byp_v4, byp_a4, byp_d4}, 64'd0);
    endtask

    typedef struct {
        logic          v, st, fl;
        inst_packet_st p;
        logic          e_ready, e_wen;
        logic [31:0]   e_data;
        logic          e_ret, e_bv;
        logic [4:0]    e_ba;
        logic [31:0]   e_bd;
    } vec_t;

    vec_t tbl[12];

    initial begin
        inst_packet_st p;
        logic          g_ready, g_wen, g_ret;
        logic [31:0]   g_data;
        int            nw, nr;
        logic [63:0]   c0;

        m_bv = 1'b0; m_ba = '0; m_bd = '0; m_cnt = '0;
        tbl[0]  = '{1, 0, 0, mk(WB_SRC_MEM, LOAD_BYTE,   5'd3,  1, 0, 32'h1003, 32'h80FF_1234, 0), 1, 1, 32'hFFFF_FF80, 1, 1, 5'd3,  32'hFFFF_FF80};
        tbl[1]  = '{1, 0, 0, mk(WB_SRC_MEM, LOAD_BYTE_U, 5'd3,  1, 0, 32'h1003, 32'h80FF_1234, 0), 1, 1, 32'h0000_0080, 1, 1, 5'd3,  32'h0000_0080};
        tbl[2]  = '{1, 0, 0, mk(WB_SRC_MEM, LOAD_HALF,   5'd7,  1, 0, 32'h2002, 32'h9ABC_0000, 0), 1, 1, 32'hFFFF_9ABC, 1, 1, 5'd7,  32'hFFFF_9ABC};
        tbl[3]  = '{1, 0, 0, mk(WB_SRC_PC4, DATA_MEM_NONE, 5'd1, 1, 32'hFFFF_FFFC, 0, 0, 0),       1, 1, 32'h0000_0000, 1, 1, 5'd1,  32'h0000_0000};
        tbl[4]  = '{1, 0, 0, mk(WB_SRC_ALU, DATA_MEM_NONE, 5'd0, 1, 0, 32'd5, 0, 0),               1, 0, 32'h0000_0005, 1, 0, 5'd1,  32'h0000_0000};
        tbl[5]  = '{1, 0, 0, mk(WB_SRC_MEM, LOAD_HALF_U, 5'd9,  1, 0, 32'h2000, 32'h1234_8765, 0), 1, 1, 32'h0000_8765, 1, 1, 5'd9,  32'h0000_8765};
        tbl[6]  = '{1, 0, 0, mk(WB_SRC_MEM, LOAD_WORD,   5'd10, 1, 0, 32'h3000, 32'hDEAD_BEEF, 0), 1, 1, 32'hDEAD_BEEF, 1, 1, 5'd10, 32'hDEAD_BEEF};
        tbl[7]  = '{1, 0, 1, mk(WB_SRC_CSR, DATA_MEM_NONE, 5'd5, 1, 0, 0, 0, 32'h1234),            1, 0, 32'h0000_1234, 0, 0, 5'd10, 32'hDEAD_BEEF};
        tbl[8]  = '{1, 0, 0, mk(WB_SRC_CSR, DATA_MEM_NONE, 5'd5, 0, 0, 0, 0, 32'h55),              1, 0, 32'h0000_0055, 1, 0, 5'd10, 32'hDEAD_BEEF};
        tbl[9]  = '{1, 0, 0, mk(WB_SRC_MEM, LOAD_BYTE,   5'd2,  1, 0, 32'h4001, 32'h0000_7F00, 0), 1, 1, 32'h0000_007F, 1, 1, 5'd2,  32'h0000_007F};
        tbl[10] = '{0, 0, 0, mk(WB_SRC_ALU, DATA_MEM_NONE, 5'd4, 1, 0, 32'd9, 0, 0),               1, 0, 32'h0000_0009, 0, 1, 5'd2,  32'h0000_007F};
        tbl[11] = '{1, 1, 0, mk(WB_SRC_ALU, DATA_MEM_NONE, 5'd4, 1, 0, 32'd9, 0, 0),               0, 0, 32'h0000_0009, 0, 1, 5'd2,  32'h0000_007F};

        p = mk(WB_SRC_ALU, DATA_MEM_NONE, 5'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, p, g_ready, g_wen, g_data, g_ret);
        chk("reset_byp_valid", {63'd0, byp_v}, 64'd0);
        chk("reset_cnt", cnt, 64'd0);

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].v, tbl[i].st, tbl[i].fl, 1'b1, tbl[i].p, g_ready, g_wen, g_data, g_ret);
            chk($sformatf("tbl%0d_ready", i), {63'd0, g_ready}, {63'd0, tbl[i].e_ready});
            chk($sformatf("tbl%0d_wen", i), {63'd0, g_wen}, {63'd0, tbl[i].e_wen});
            chk($sformatf("tbl%0d_data", i), {32'd0, g_data}, {32'd0, tbl[i].e_data});
            chk($sformatf("tbl%0d_ret", i), {63'd0, g_ret}, {63'd0, tbl[i].e_ret});
            chk($sformatf("tbl%0d_byp", i), {26'd0, byp_v, byp_a, byp_d}, {26'd0, tbl[i].e_bv, tbl[i].e_ba, tbl[i].e_bd});
        end

        c0 = m_cnt;
        nw = 0;
        nr = 0;
        p = mk(WB_SRC_ALU, DATA_MEM_NONE, 5'd12, 1, 0, 32'hCAFE, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 1, p, g_ready, g_wen, g_data, g_ret);
            chk("stall_ready", {63'd0, g_ready}, 64'd0);
            nw += int'(g_wen);
            nr += int'(g_ret);
        end
        cycle(1, 0, 0, 1, p, g_ready, g_wen, g_data, g_ret);
        nw += int'(g_wen);
        nr += int'(g_ret);
        chk("stall_writes", 64'(nw), 64'd1);
        chk("stall_retires", 64'(nr), 64'd1);
        chk("stall_cnt", cnt, c0 + 64'd1);

        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 0, 0, p, g_ready, g_wen, g_data, g_ret);
            chk("reset_no_write", {63'd0, g_wen}, 64'd0);
        end
        chk("midreset_cnt", cnt, 64'd0);
        chk("midreset_byp", {26'd0, byp_v, byp_a, byp_d}, 64'd0);

        for (int i = 0; i < 15; i++) cycle(1, 0, 0, 1, p, g_ready, g_wen, g_data, g_ret);
        chk("cnt4_max", {60'd0, cnt4}, 64'd15);
        cycle(1, 0, 0, 1, p, g_ready, g_wen, g_data, g_ret);
        chk("cnt4_wrap", {60'd0, cnt4}, 64'd0);
        chk("cnt_16", cnt, 64'd16);

        for (int i = 0; i < 400; i++) begin
            data_mem_op_e op;
            op = data_mem_op_e'($urandom_range(1, 5));
            p = mk(wb_src_e'($urandom_range(0, 3)), op,
                   $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom),
                   $urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, $urandom);
            if (op == LOAD_HALF || op == LOAD_HALF_U) p.alu_result[0] = 1'b0;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 49) != 0, p, g_ready, g_wen, g_data, g_ret);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
